hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Produces the `stall` signal consumed by the D/E pipeline register, the F/D hold, and the PC hold, plus D-stage forwarding selects, for the 5-stage MIPS core.
- Keeps its own shadow pipeline of destination register and Tnew for the E, M and W stages. This shadow pipeline is loaded from `ir_d` exactly as the D/E register loads, including bubble insertion on stall.
- Also models the multiply/divide unit busy window, so HI/LO-class instructions wait in D.

Parameters:
- MULT_CYC, 5, busy cycles after mult/multu leaves E
- DIV_CYC, 10, busy cycles after div/divu leaves E

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ir_d  in  32  instruction currently in D stage (0 = nop)
- stall  out  1  1 = hold PC and F/D, clear D/E to bubble
- md_busy  out  1  mult/div unit busy (counter nonzero)
- fwd_rs_d  out  2  D-stage rs source: 0 regfile, 1 E pc8, 2 M result, 3 W result
- fwd_rt_d  out  2  D-stage rt source, same encoding

Behaviour:
- Decoding of `ir_d` (combinational):
  - dst: R-type calc, mfhi, mflo and jalr write rd; I-type calc and loads write rt; jal writes 31; all others write 0.
  - Tnew at E: calc/mfhi/mflo = 1; load = 2; jal/jalr = 0; others 0 with dst = 0.
  - Tuse rs: beq/bne/blez/bgtz/bltz/bgez/jr/jalr = 0; calc, load, store, md ops = 1.
  - Tuse rt: beq/bne = 0; R-calc, mult/div = 1; store = 2; otherwise unused.
  - md_class: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Shadow registers: e_dst[4:0], e_tnew[1:0], e_md[1:0], m_dst, m_tnew, w_dst.
  - e_md encoding: 0 none, 1 mult start, 2 div start.
- Update at posedge clk:
  - reset: all shadow regs <= 0, md counter <= 0.
  - stall: E shadow <= bubble (0,0,0). M and W still advance.
  - otherwise: E shadow <= decode(`ir_d`).
  - Always (outside reset): m_dst <= e_dst; m_tnew <= (e_tnew==0 ? 0 : e_tnew-1); w_dst <= m_dst.
- Data stall (combinational), for each used source r in {rs, rt} with r != 0:
  - stall if e_dst==r and e_tnew > tuse(r);
  - stall if m_dst==r and m_tnew > tuse(r).
  - W stage never stalls.
- MD counter (5-bit):
  - If e_md==1, load MULT_CYC; if e_md==2, load DIV_CYC.
  - Else, if nonzero, decrement.
  - `md_busy` = counter != 0.
  - MD stall: D holds md_class and (`md_busy` or e_md != 0).
- `stall` = data stall OR MD stall.
- Forwarding (combinational), per source, priority E > M > W:
  - 1 if e_dst==r, r!=0, e_tnew==0;
  - else 2 if m_dst==r, r!=0, m_tnew==0;
  - else 3 if w_dst==r, r!=0;
  - else 0.
  - Selects are don't-care while `stall` = 1.
- Reset values: `stall`=0, `md_busy`=0, fwd_*=0 (`ir_d` assumed 0 under reset).
- Reset mid-divide clears the counter immediately at the next edge.
- A new md op back-to-back cannot reach E while busy, because the MD stall holds it in D.
- Register 0 never stalls and never forwards.

Test Plan:
- Load-use into branch: lw $1,0($0) (0x8C010000), then beq $1,$0 (0x10200000).
  -> stall=1 for 2 cycles while the lw is in E and then M; beq leaves D with fwd_rs_d=3.
- Load-use into calc: lw $1 then addu $2,$1,$1 (0x00211021).
  -> stall=1 for exactly 1 cycle; next cycle fwd_rs_d=fwd_rt_d=3.
- Calc-to-branch: ori $3,$0,5 (0x34030005), then beq $3,$0.
  -> 1 stall cycle, then fwd_rs_d=2. Also jal then jr $31 -> no stall, fwd_rs_d=1.
- Multiply then mflo: mult $1,$2 (0x00220018), then mflo $4 (0x00002012).
  -> stall=1 for 1+MULT_CYC=6 cycles; md_busy high 5 cycles; mflo then proceeds.
- div (0x0022001A) followed by reset asserted on the 3rd busy cycle.
  -> next edge: md_busy=0, stall=0, all fwd=0.
- $0 destination: ori $0,$0,1, then addu $2,$0,$0.
  -> stall=0, fwd_rs_d=fwd_rt_d=0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall and D-stage forwarding control for the 5-stage MIPS core.
// Tracks E/M/W destinations and Tnew in a shadow pipeline, plus the mult/div busy window.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir_d,
   output logic        stall,
   output logic        md_busy,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic [4:0] w_rd;
   logic       w_unused;

   assign w_op     = ir_d[31:26];
   assign w_rs     = ir_d[25:21];
   assign w_rt     = ir_d[20:16];
   assign w_rd     = ir_d[15:11];
   assign w_funct  = ir_d[5:0];
   assign w_unused = &ir_d[10:6];

   logic [4:0] w_dst;
   logic [1:0] w_tnew;
   logic [1:0] w_mdStart;
   logic       w_mdClass;
   logic       w_useRs;
   logic       w_useRt;
   logic [1:0] w_tuseRs;
   logic [1:0] w_tuseRt;

   logic [4:0] r_eDst;
   logic [1:0] r_eTnew;
   logic [1:0] r_eMd;
   logic [4:0] r_mDst;
   logic [1:0] r_mTnew;
   logic [4:0] r_wDst;
   logic [4:0] r_mdCount;

   logic       w_dataStall;
   logic       w_mdStall;

   // Decode the D-stage instruction into destination, Tnew, source Tuse and md class.
   always_comb begin
      w_dst     = 5'd0;
      w_tnew    = 2'd0;
      w_mdStart = 2'd0;
      w_mdClass = 1'b0;
      w_useRs   = 1'b0;
      w_useRt   = 1'b0;
      w_tuseRs  = 2'd0;
      w_tuseRt  = 2'd0;
      case (w_op)
         6'h00: begin
            case (w_funct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  w_dst    = w_rd;
                  w_tnew   = 2'd1;
                  w_useRs  = 1'b1;
                  w_tuseRs = 2'd1;
                  w_useRt  = 1'b1;
                  w_tuseRt = 2'd1;
               end
               6'h10, 6'h12: begin
                  w_dst     = w_rd;
                  w_tnew    = 2'd1;
                  w_mdClass = 1'b1;
               end
               6'h11, 6'h13: begin
                  w_mdClass = 1'b1;
                  w_useRs   = 1'b1;
                  w_tuseRs  = 2'd1;
               end
               6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  w_mdClass = 1'b1;
                  w_mdStart = w_funct[1] ? 2'd2 : 2'd1;
                  w_useRs   = 1'b1;
                  w_tuseRs  = 2'd1;
                  w_useRt   = 1'b1;
                  w_tuseRt  = 2'd1;
               end
               6'h08: begin
                  w_useRs  = 1'b1;
                  w_tuseRs = 2'd0;
               end
               6'h09: begin
                  w_dst    = w_rd;
                  w_tnew   = 2'd0;
                  w_useRs  = 1'b1;
                  w_tuseRs = 2'd0;
               end
               default: ;
            endcase
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            w_dst    = w_rt;
            w_tnew   = 2'd1;
            w_useRs  = 1'b1;
            w_tuseRs = 2'd1;
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            w_dst    = w_rt;
            w_tnew   = 2'd2;
            w_useRs  = 1'b1;
            w_tuseRs = 2'd1;
         end
         6'h28, 6'h29, 6'h2B: begin
            w_useRs  = 1'b1;
            w_tuseRs = 2'd1;
            w_useRt  = 1'b1;
            w_tuseRt = 2'd2;
         end
         6'h04, 6'h05: begin
            w_useRs  = 1'b1;
            w_useRt  = 1'b1;
         end
         6'h01, 6'h06, 6'h07: begin
            w_useRs  = 1'b1;
         end
         6'h03: begin
            w_dst  = 5'd31;
            w_tnew = 2'd0;
         end
         default: ;
      endcase
   end

   // Shadow pipeline mirrors the D/E register, with a bubble loaded into E on stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_eDst  <= 5'd0;
         r_eTnew <= 2'd0;
         r_eMd   <= 2'd0;
         r_mDst  <= 5'd0;
         r_mTnew <= 2'd0;
         r_wDst  <= 5'd0;
      end else begin
         if (stall) begin
            r_eDst  <= 5'd0;
            r_eTnew <= 2'd0;
            r_eMd   <= 2'd0;
         end else begin
            r_eDst  <= w_dst;
            r_eTnew <= w_tnew;
            r_eMd   <= w_mdStart;
         end
         r_mDst  <= r_eDst;
         r_mTnew <= (r_eTnew == 2'd0) ? 2'd0 : r_eTnew - 2'd1;
         r_wDst  <= r_mDst;
      end
   end

   // Busy window starts counting on the edge where the mult/div leaves E.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mdCount <= 5'd0;
      end else if (r_eMd == 2'd1) begin
         r_mdCount <= 5'(MULT_CYC);
      end else if (r_eMd == 2'd2) begin
         r_mdCount <= 5'(DIV_CYC);
      end else if (r_mdCount != 5'd0) begin
         r_mdCount <= r_mdCount - 5'd1;
      end
   end

   assign md_busy = (r_mdCount != 5'd0);

   // A source stalls only if a younger producer cannot deliver by the time it is used.
   always_comb begin
      w_dataStall = 1'b0;
      if (w_useRs && (w_rs != 5'd0)) begin
         if ((r_eDst == w_rs) && (r_eTnew > w_tuseRs)) w_dataStall = 1'b1;
         if ((r_mDst == w_rs) && (r_mTnew > w_tuseRs)) w_dataStall = 1'b1;
      end
      if (w_useRt && (w_rt != 5'd0)) begin
         if ((r_eDst == w_rt) && (r_eTnew > w_tuseRt)) w_dataStall = 1'b1;
         if ((r_mDst == w_rt) && (r_mTnew > w_tuseRt)) w_dataStall = 1'b1;
      end
   end

   assign w_mdStall = w_mdClass && (md_busy || (r_eMd != 2'd0));
   assign stall     = w_dataStall || w_mdStall;

   // Forwarding picks the youngest stage that already holds the value, E before M before W.
   always_comb begin
      fwd_rs_d = 2'd0;
      if (w_rs != 5'd0) begin
         if ((r_eDst == w_rs) && (r_eTnew == 2'd0))      fwd_rs_d = 2'd1;
         else if ((r_mDst == w_rs) && (r_mTnew == 2'd0)) fwd_rs_d = 2'd2;
         else if (r_wDst == w_rs)                        fwd_rs_d = 2'd3;
      end
   end

   always_comb begin
      fwd_rt_d = 2'd0;
      if (w_rt != 5'd0) begin
         if ((r_eDst == w_rt) && (r_eTnew == 2'd0))      fwd_rt_d = 2'd1;
         else if ((r_mDst == w_rt) && (r_mTnew == 2'd0)) fwd_rt_d = 2'd2;
         else if (r_wDst == w_rt)                        fwd_rt_d = 2'd3;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, calc-to-branch, jal/jr, mult/mflo, reset mid-divide, $0.
module tb_hazard_ctrl;

   localparam logic [31:0] LW1    = 32'h8C010000;
   localparam logic [31:0] BEQ1   = 32'h10200000;
   localparam logic [31:0] ADDU2  = 32'h00211021;
   localparam logic [31:0] ADDU5  = 32'h00212821;
   localparam logic [31:0] ORI3   = 32'h34030005;
   localparam logic [31:0] BEQ3   = 32'h10600000;
   localparam logic [31:0] JAL    = 32'h0C000000;
   localparam logic [31:0] JR31   = 32'h03E00008;
   localparam logic [31:0] MULT   = 32'h00220018;
   localparam logic [31:0] MFLO4  = 32'h00002012;
   localparam logic [31:0] DIV    = 32'h0022001A;
   localparam logic [31:0] ORI0   = 32'h34000001;
   localparam logic [31:0] ADDU00 = 32'h00001021;

   logic        clk;
   logic        reset;
   logic [31:0] ir_d;
   logic        stall;
   logic        md_busy;
   logic [1:0]  fwd_rs_d;
   logic [1:0]  fwd_rt_d;

   int passCount;
   int checkCount;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .ir_d     (ir_d),
      .stall    (stall),
      .md_busy  (md_busy),
      .fwd_rs_d (fwd_rs_d),
      .fwd_rt_d (fwd_rt_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ir_d  = 32'h0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ir_d  = 32'h0;
      step();
      step();
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL reset_stall got=%b exp=0", stall);
      else passCount++;
      checkCount++;
      if (md_busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", md_busy);
      else passCount++;
      checkCount++;
      if ({fwd_rs_d, fwd_rt_d} !== 4'b0) $display("[TB] FAIL reset_fwd got=%b%b exp=0000", fwd_rs_d, fwd_rt_d);
      else passCount++;
      reset = 1'b0;
   endtask

   task automatic test_load_branch();
      do_reset();
      ir_d = LW1;
      #1;
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL lb_lw_in_d got=%b exp=0", stall);
      else passCount++;
      step();
      ir_d = BEQ1;
      #1;
      checkCount++;
      if (stall !== 1'b1) $display("[TB] FAIL lb_stall_e got=%b exp=1", stall);
      else passCount++;
      step();
      checkCount++;
      if (stall !== 1'b1) $display("[TB] FAIL lb_stall_m got=%b exp=1", stall);
      else passCount++;
      step();
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL lb_release got=%b exp=0", stall);
      else passCount++;
      checkCount++;
      if (fwd_rs_d !== 2'd3) $display("[TB] FAIL lb_fwd_rs got=%0d exp=3", fwd_rs_d);
      else passCount++;
   endtask

   task automatic test_load_calc();
      do_reset();
      ir_d = LW1;
      step();
      ir_d = ADDU2;
      #1;
      checkCount++;
      if (stall !== 1'b1) $display("[TB] FAIL lc_stall got=%b exp=1", stall);
      else passCount++;
      step();
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL lc_release got=%b exp=0", stall);
      else passCount++;
      step();
      ir_d = ADDU5;
      #1;
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL lc_next_stall got=%b exp=0", stall);
      else passCount++;
      checkCount++;
      if ({fwd_rs_d, fwd_rt_d} !== {2'd3, 2'd3}) $display("[TB] FAIL lc_fwd got=%0d,%0d exp=3,3", fwd_rs_d, fwd_rt_d);
      else passCount++;
   endtask

   task automatic test_calc_branch();
      do_reset();
      ir_d = ORI3;
      step();
      ir_d = BEQ3;
      #1;
      checkCount++;
      if (stall !== 1'b1) $display("[TB] FAIL cb_stall got=%b exp=1", stall);
      else passCount++;
      step();
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL cb_release got=%b exp=0", stall);
      else passCount++;
      checkCount++;
      if (fwd_rs_d !== 2'd2) $display("[TB] FAIL cb_fwd_rs got=%0d exp=2", fwd_rs_d);
      else passCount++;
      ir_d = JAL;
      step();
      ir_d = JR31;
      #1;
      checkCount++;
      if (stall !== 1'b0) $display("[TB] FAIL jr_stall got=%b exp=0", stall);
      else passCount++;
      checkCount++;
      if (fwd_rs_d !== 2'd1) $display("[TB] FAIL jr_fwd_rs got=%0d exp=1", fwd_rs_d);
      else passCount++;
   endtask

   task automatic test_mult();
      do_reset();
      ir_d = MULT;
      step();
      ir_d = MFLO4;
      for (int i = 0; i < 6; i++) begin
         #1;
         checkCount++;
         if (stall !== 1'b1) $display("[TB] FAIL md_stall_%0d got=%b exp=1", i, stall);
         else passCount++;
         checkCount++;
         if (md_busy !== (i != 0)) $display("[TB] FAIL md_busy_%0d got=%b exp=%b", i, md_busy, (i != 0));
         else passCount++;
         step();
      end
      #1;
      checkCount++;
      if ({stall, md_busy} !== 2'b00) $display("[TB] FAIL md_done got=%b%b exp=00", stall, md_busy);
      else passCount++;
   endtask

   task automatic test_div_reset();
      do_reset();
      ir_d = DIV;
      step();
      ir_d = 32'h0;
      step();
      step();
      step();
      checkCount++;
      if (md_busy !== 1'b1) $display("[TB] FAIL div_busy got=%b exp=1", md_busy);
      else passCount++;
      reset = 1'b1;
      step();
      checkCount++;
      if ({stall, md_busy} !== 2'b00) $display("[TB] FAIL div_reset got=%b%b exp=00", stall, md_busy);
      else passCount++;
      checkCount++;
      if ({fwd_rs_d, fwd_rt_d} !== 4'b0) $display("[TB] FAIL div_reset_fwd got=%0d,%0d exp=0,0", fwd_rs_d, fwd_rt_d);
      else passCount++;
      reset = 1'b0;
   endtask

   task automatic test_zero_dst();
      do_reset();
      ir_d = ORI0;
      step();
      ir_d = ADDU00;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkCount++;
         if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0)
            $display("[TB] FAIL zero_%0d got=stall%b fwd%0d,%0d exp=0,0,0", i, stall, fwd_rs_d, fwd_rt_d);
         else passCount++;
         step();
      end
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      reset      = 1'b1;
      ir_d       = 32'h0;
      test_reset();
      test_load_branch();
      test_load_calc();
      test_calc_branch();
      test_mult();
      test_div_reset();
      test_zero_dst();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
